// File: rtl/io_port_bridge.sv
// Memory-mapped I/O port bridge: snooped stores go out over valid/ready, device words come back in.
// Optional IO_LOOPBACK_EN routes the TX output straight into the RX FIFO.
module io_port_bridge #(
  parameter logic [15:0] IO_ADDR  = 16'hFC00,
  parameter int          TX_DEPTH = 4,
  parameter int          RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_we,
  input  logic        io_rd_ack,
  output logic [15:0] processor_input,
  output logic        rx_empty,
  output logic        tx_full,
  output logic        tx_overflow,
  output logic [15:0] dev_tx_data,
  output logic        dev_tx_valid,
  input  logic        dev_tx_ready,
  input  logic [15:0] dev_rx_data,
  input  logic        dev_rx_valid,
  output logic        dev_rx_ready
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

  tx_state_t state;

  logic [15:0]  tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wr;
  logic [TAW-1:0] tx_rd;
  logic [TAW:0]   tx_cnt;

  logic [15:0]  rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wr;
  logic [RAW-1:0] rx_rd;
  logic [RAW:0]   rx_cnt;

  logic        tx_valid_q;
  logic [15:0] tx_data_q;
  logic        ovf_q;

  logic        rx_full;
  logic        tx_store;
  logic        tx_push;
  logic        tx_pop;
  logic        tx_ready_eff;
  logic        tx_accept;
  logic        rx_in_valid;
  logic [15:0] rx_in_data;
  logic        rx_push;
  logic        rx_pop;

  assign tx_full  = tx_cnt == (TAW+1)'(TX_DEPTH);
  assign rx_full  = rx_cnt == (RAW+1)'(RX_DEPTH);
  assign rx_empty = rx_cnt == '0;

  assign tx_store = mem_we && (mem_addr == IO_ADDR);
  assign tx_push  = tx_store && !tx_full;
  assign tx_pop   = (state == IDLE) && (tx_cnt != '0);

`ifdef IO_LOOPBACK_EN
  // Internal path: the RX FIFO plays the device
  logic unused_dev;
  assign unused_dev   = ^{dev_tx_ready, dev_rx_data, dev_rx_valid};
  assign tx_ready_eff = !rx_full;
  assign rx_in_valid  = tx_valid_q;
  assign rx_in_data   = tx_data_q;
  assign dev_tx_valid = 1'b0;
  assign dev_rx_ready = 1'b0;
`else
  assign tx_ready_eff = dev_tx_ready;
  assign rx_in_valid  = dev_rx_valid;
  assign rx_in_data   = dev_rx_data;
  assign dev_tx_valid = tx_valid_q;
  assign dev_rx_ready = !rx_full;
`endif

  assign tx_accept   = (state == SEND) && tx_ready_eff;
  assign rx_push     = rx_in_valid && !rx_full;
  assign rx_pop      = io_rd_ack && !rx_empty;
  assign dev_tx_data = tx_data_q;
  assign tx_overflow = ovf_q;

  assign processor_input = rx_empty ? 16'h0000 : rx_mem[rx_rd];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= mem_data;
    if (rx_push) rx_mem[rx_wr] <= rx_in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (tx_store && tx_full) ovf_q <= 1'b1;
      if (tx_push) tx_wr <= tx_wr + TAW'(1);
      if (tx_pop)  tx_rd <= tx_rd + TAW'(1);
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + (TAW+1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (TAW+1)'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tx_pop) begin
            tx_data_q  <= tx_mem[tx_rd];
            tx_valid_q <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (tx_accept) begin
            tx_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + RAW'(1);
      if (rx_pop)  rx_rd <= rx_rd + RAW'(1);
      unique case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (RAW+1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (RAW+1)'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

endmodule
